// File: rtl/mem_pkg.sv
// mem_pkg: cache access-select codes, exception causes and LSU FSM states
// shared by the load/store unit and the data cache.
package mem_pkg;

    localparam logic [3:0] SEL_IDLE = 4'b0000;
    localparam logic [3:0] SEL_LB   = 4'b1000;
    localparam logic [3:0] SEL_LH   = 4'b1001;
    localparam logic [3:0] SEL_LW   = 4'b1010;
    localparam logic [3:0] SEL_LBU  = 4'b1100;
    localparam logic [3:0] SEL_LHU  = 4'b1101;
    localparam logic [3:0] SEL_SB   = 4'b1011;
    localparam logic [3:0] SEL_SH   = 4'b1110;
    localparam logic [3:0] SEL_SW   = 4'b1111;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_EXC    = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_decode.sv
// lsu_decode: maps funct3 + store flag to a cache select code and flags
// misaligned half/word addresses; illegal funct3 falls back to LW/SW.
module lsu_decode
    import mem_pkg::*;
(
    input  logic       store_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] sel_o,
    output logic       misaligned_o
);

    logic half;
    logic word;

    always_comb begin
        sel_o = store_i ? (funct3_i == 3'b000 ? SEL_SB :
                           funct3_i == 3'b001 ? SEL_SH : SEL_SW)
                        : (funct3_i == 3'b000 ? SEL_LB :
                           funct3_i == 3'b001 ? SEL_LH :
                           funct3_i == 3'b100 ? SEL_LBU :
                           funct3_i == 3'b101 ? SEL_LHU : SEL_LW);
        half = (sel_o == SEL_LH) || (sel_o == SEL_LHU) || (sel_o == SEL_SH);
        word = (sel_o == SEL_LW) || (sel_o == SEL_SW);
        misaligned_o = (half && addr_lo_i[0]) || (word && addr_lo_i != 2'b00);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU; latches one request, holds it on the
// cache while busy, times out stuck accesses and returns load data to WB.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic [31:0] cache_addr_o,
    output logic [31:0] cache_wdata_o,
    output logic [3:0]  cache_sel_o,
    input  logic [31:0] cache_rdata_i,
    input  logic        cache_busy_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        exc_valid_o,
    output logic [3:0]  exc_cause_o,
    output logic [31:0] exc_addr_o
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
    logic [3:0]  sel_q, sel_d, exc_cause_q, exc_cause_d;
    logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic        store_q, store_d, flushed_q, flushed_d, wb_valid_q, wb_valid_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic [3:0]  dec_sel;
    logic        dec_mis;
    logic        access;

    lsu_decode u_decode (
        .store_i      (req_store_i),
        .funct3_i     (req_funct3_i),
        .addr_lo_i    (req_addr_i[1:0]),
        .sel_o        (dec_sel),
        .misaligned_o (dec_mis)
    );

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        rd_d        = rd_q;
        store_d     = store_q;
        flushed_d   = flushed_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        case (state_q)
            ST_IDLE: if (req_valid_i && !flush_i) begin
                addr_d    = req_addr_i;
                wdata_d   = req_wdata_i;
                sel_d     = dec_sel;
                rd_d      = req_rd_i;
                store_d   = req_store_i;
                cnt_d     = 8'd0;
                flushed_d = 1'b0;
                state_d   = dec_mis ? ST_EXC : ST_ACCESS;
                if (dec_mis) begin
                    exc_cause_d = req_store_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                    exc_addr_d  = req_addr_i;
                end
            end
            ST_ACCESS: begin
                // a flush anywhere in the access kills the writeback/exception, not the access
                flushed_d = flushed_q | flush_i;
                if (!cache_busy_i) begin
                    state_d = ST_IDLE;
                    if (!store_q && !flushed_d) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = cache_rdata_i;
                        wb_rd_d    = rd_q;
                    end
                end else begin
                    cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_inc[7:0];
                    if (cnt_inc >= 9'(BUSY_TIMEOUT)) begin
                        state_d = flushed_d ? ST_IDLE : ST_EXC;
                        if (!flushed_d) begin
                            exc_cause_d = store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                            exc_addr_d  = addr_q;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= SEL_IDLE;
            rd_q        <= '0;
            store_q     <= 1'b0;
            flushed_q   <= 1'b0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            exc_cause_q <= '0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            store_q     <= store_d;
            flushed_q   <= flushed_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign access        = (state_q == ST_ACCESS);
    assign req_ready_o   = (state_q == ST_IDLE);
    assign cache_sel_o   = access ? sel_q : SEL_IDLE;
    assign cache_addr_o  = access ? addr_q : 32'd0;
    assign cache_wdata_o = access ? wdata_q : 32'd0;
    assign wb_valid_o    = wb_valid_q;
    assign wb_data_o     = wb_data_q;
    assign wb_rd_o       = wb_rd_q;
    assign exc_valid_o   = (state_q == ST_EXC);
    assign exc_cause_o   = exc_cause_q;
    assign exc_addr_o    = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus randomized requests checked
// against a cycle-count model of the LSU access/writeback/exception timing.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i, req_ready_o, req_store_i, flush_i, cache_busy_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i, cache_addr_o, cache_wdata_o, cache_rdata_i;
    logic [4:0]  req_rd_i, wb_rd_o;
    logic [3:0]  cache_sel_o, exc_cause_o;
    logic        wb_valid_o, exc_valid_o;
    logic [31:0] wb_data_o, exc_addr_o;

    int checks = 0;
    int errors = 0;

    logic [3:0] ld_tab [8] = '{4'b1000, 4'b1001, 4'b1010, 4'b1010, 4'b1100, 4'b1101, 4'b1010, 4'b1010};
    logic [3:0] st_tab [8] = '{4'b1011, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};

    load_store_unit #(.BUSY_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i), .flush_i(flush_i),
        .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o), .cache_sel_o(cache_sel_o),
        .cache_rdata_i(cache_rdata_i), .cache_busy_i(cache_busy_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
        .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_addr_o(exc_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
        req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
    endtask

    task automatic test_reset();
        logic [143:0] obs;
        obs = {req_ready_o, cache_sel_o, cache_addr_o, cache_wdata_o, wb_valid_o, wb_data_o,
               wb_rd_o, exc_valid_o, exc_cause_o, exc_addr_o};
        checks++; if (obs !== {1'b1, 143'd0}) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b1, 143'd0}); end
    endtask

    task automatic test_lw();
        drive(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        cache_busy_i = 1'b0; cache_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i); req_valid_i = 1'b0;
        checks++; if (cache_sel_o !== 4'b1010) begin errors++; $display("FAIL lw_sel: got %b want 1010", cache_sel_o); end
        checks++; if (cache_addr_o !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 100", cache_addr_o); end
        @(negedge clk_i);
        checks++; if ({wb_valid_o, wb_data_o, wb_rd_o} !== {1'b1, 32'hDEADBEEF, 5'd5})
            begin errors++; $display("FAIL lw_wb: got v=%b d=%h rd=%0d want v=1 d=deadbeef rd=5", wb_valid_o, wb_data_o, wb_rd_o); end
        checks++; if (req_ready_o !== 1'b1 || cache_sel_o !== 4'b0) begin errors++; $display("FAIL lw_ready: got rdy=%b sel=%b want rdy=1 sel=0000", req_ready_o, cache_sel_o); end
    endtask

    task automatic test_sh_busy();
        drive(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i); req_valid_i = 1'b0;
            checks++; if ({cache_sel_o, cache_addr_o, cache_wdata_o, req_ready_o, wb_valid_o} !== {4'b1110, 32'h202, 32'h1234ABCD, 1'b0, 1'b0})
                begin errors++; $display("FAIL sh_busy_c%0d: got sel=%b a=%h wd=%h rdy=%b wbv=%b want sel=1110 a=202 wd=1234abcd rdy=0 wbv=0", k, cache_sel_o, cache_addr_o, cache_wdata_o, req_ready_o, wb_valid_o); end
            cache_busy_i = (k <= 3);
        end
        @(negedge clk_i);
        checks++; if ({cache_sel_o, wb_valid_o, req_ready_o} !== {4'b0, 1'b0, 1'b1})
            begin errors++; $display("FAIL sh_done: got sel=%b wbv=%b rdy=%b want 0000 0 1", cache_sel_o, wb_valid_o, req_ready_o); end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 3'b001, 32'h101, 32'h0, 5'd3);
        @(negedge clk_i); req_valid_i = 1'b0;
        checks++; if ({cache_sel_o, exc_valid_o, exc_cause_o, exc_addr_o} !== {4'b0, 1'b1, 4'd4, 32'h101})
            begin errors++; $display("FAIL lh_misaligned: got sel=%b ev=%b c=%0d a=%h want 0000 1 4 101", cache_sel_o, exc_valid_o, exc_cause_o, exc_addr_o); end
        @(negedge clk_i);
        checks++; if ({exc_valid_o, req_ready_o, cache_sel_o} !== {1'b0, 1'b1, 4'b0})
            begin errors++; $display("FAIL lh_after: got ev=%b rdy=%b sel=%b want 0 1 0000", exc_valid_o, req_ready_o, cache_sel_o); end
    endtask

    task automatic test_timeout();
        drive(1'b1, 3'b010, 32'h300, 32'h55, 5'd0);
        cache_busy_i = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_i); req_valid_i = 1'b0;
            checks++; if ({cache_sel_o, exc_valid_o} !== {4'b1111, 1'b0})
                begin errors++; $display("FAIL sw_busy_c%0d: got sel=%b ev=%b want 1111 0", k, cache_sel_o, exc_valid_o); end
        end
        @(negedge clk_i); cache_busy_i = 1'b0;
        checks++; if ({exc_valid_o, exc_cause_o, exc_addr_o, cache_sel_o} !== {1'b1, 4'd7, 32'h300, 4'b0})
            begin errors++; $display("FAIL sw_timeout: got ev=%b c=%0d a=%h sel=%b want 1 7 300 0000", exc_valid_o, exc_cause_o, exc_addr_o, cache_sel_o); end
        @(negedge clk_i);
        checks++; if ({exc_valid_o, req_ready_o} !== 2'b01) begin errors++; $display("FAIL sw_after: got ev=%b rdy=%b want 0 1", exc_valid_o, req_ready_o); end
    endtask

    task automatic test_flush();
        drive(1'b0, 3'b000, 32'h43, 32'h0, 5'd9);
        cache_busy_i = 1'b0; cache_rdata_i = 32'h77;
        @(negedge clk_i); req_valid_i = 1'b0; flush_i = 1'b1;
        checks++; if (cache_sel_o !== 4'b1000) begin errors++; $display("FAIL flush_lb_sel: got %b want 1000", cache_sel_o); end
        @(negedge clk_i); flush_i = 1'b0;
        checks++; if ({wb_valid_o, req_ready_o} !== 2'b01) begin errors++; $display("FAIL flush_lb_wb: got wbv=%b rdy=%b want 0 1", wb_valid_o, req_ready_o); end
        drive(1'b0, 3'b010, 32'h10, 32'h0, 5'd4); flush_i = 1'b1;
        @(negedge clk_i); req_valid_i = 1'b0; flush_i = 1'b0;
        checks++; if ({req_ready_o, cache_sel_o, exc_valid_o} !== {1'b1, 4'b0, 1'b0})
            begin errors++; $display("FAIL flush_idle_drop: got rdy=%b sel=%b ev=%b want 1 0000 0", req_ready_o, cache_sel_o, exc_valid_o); end
        drive(1'b0, 3'b010, 32'h20, 32'h0, 5'd4); cache_busy_i = 1'b1;
        @(negedge clk_i); req_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i); flush_i = 1'b0;
        repeat (TO - 1) @(negedge clk_i);
        cache_busy_i = 1'b0;
        checks++; if ({exc_valid_o, req_ready_o, cache_sel_o, wb_valid_o} !== {1'b0, 1'b1, 4'b0, 1'b0})
            begin errors++; $display("FAIL flush_timeout: got ev=%b rdy=%b sel=%b wbv=%b want 0 1 0000 0", exc_valid_o, req_ready_o, cache_sel_o, wb_valid_o); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 3'b010, 32'h40, 32'h0, 5'd6); cache_busy_i = 1'b1; cache_rdata_i = 32'h99;
        @(negedge clk_i); req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (cache_sel_o !== 4'b1010) begin errors++; $display("FAIL rstmid_pre: got %b want 1010", cache_sel_o); end
        #2 rst_i = 1'b0;
        #1 test_reset();
        @(negedge clk_i); cache_busy_i = 1'b0; rst_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++; if ({wb_valid_o, exc_valid_o, req_ready_o} !== 3'b001)
                begin errors++; $display("FAIL rstmid_after_%0d: got wbv=%b ev=%b rdy=%b want 0 0 1", k, wb_valid_o, exc_valid_o, req_ready_o); end
        end
    endtask

    // Each request: misaligned -> exception next cycle; otherwise the select is
    // held for nb+1 cycles (or TO cycles then a fault), loads write back after.
    task automatic test_back_to_back_random(input int n);
        logic st; logic [2:0] f3; logic [31:0] a, wd, rdata; logic [4:0] rd;
        logic [3:0] sel; int bytes, nb, ncyc; logic mis, tmo;
        for (int i = 0; i < n; i++) begin
            st = 1'($urandom); f3 = 3'($urandom); a = $urandom; wd = $urandom;
            rd = 5'($urandom); rdata = $urandom; nb = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            bytes = st ? (f3 == 0 ? 1 : f3 == 1 ? 2 : 4) : (f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4);
            mis = (a % bytes) != 0;
            sel = st ? st_tab[f3] : ld_tab[f3];
            tmo = nb >= TO;
            ncyc = tmo ? TO : nb + 1;
            checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %b want 1", i, req_ready_o); end
            drive(st, f3, a, wd, rd); cache_busy_i = 1'b0; cache_rdata_i = rdata;
            if (mis) begin
                @(negedge clk_i); req_valid_i = 1'b0;
                checks++; if ({cache_sel_o, exc_valid_o, exc_cause_o, exc_addr_o, wb_valid_o} !== {4'b0, 1'b1, st ? 4'd6 : 4'd4, a, 1'b0})
                    begin errors++; $display("FAIL rnd%0d_mis: got sel=%b ev=%b c=%0d a=%h wbv=%b want 0000 1 %0d %h 0", i, cache_sel_o, exc_valid_o, exc_cause_o, exc_addr_o, wb_valid_o, st ? 6 : 4, a); end
                @(negedge clk_i);
                continue;
            end
            for (int k = 1; k <= ncyc; k++) begin
                @(negedge clk_i); req_valid_i = 1'b0;
                checks++; if ({cache_sel_o, cache_addr_o, cache_wdata_o, req_ready_o, wb_valid_o, exc_valid_o} !== {sel, a, wd, 1'b0, 1'b0, 1'b0})
                    begin errors++; $display("FAIL rnd%0d_acc_c%0d: got sel=%b a=%h wd=%h rdy=%b wbv=%b ev=%b want sel=%b a=%h wd=%h 0 0 0", i, k, cache_sel_o, cache_addr_o, cache_wdata_o, req_ready_o, wb_valid_o, exc_valid_o, sel, a, wd); end
                cache_busy_i = (k <= nb);
            end
            @(negedge clk_i); cache_busy_i = 1'b0;
            if (tmo) begin
                checks++; if ({exc_valid_o, exc_cause_o, exc_addr_o, cache_sel_o, wb_valid_o} !== {1'b1, st ? 4'd7 : 4'd5, a, 4'b0, 1'b0})
                    begin errors++; $display("FAIL rnd%0d_tmo: got ev=%b c=%0d a=%h sel=%b wbv=%b want 1 %0d %h 0000 0", i, exc_valid_o, exc_cause_o, exc_addr_o, cache_sel_o, wb_valid_o, st ? 7 : 5, a); end
                @(negedge clk_i);
            end else begin
                checks++; if ({wb_valid_o, cache_sel_o, exc_valid_o} !== {!st, 4'b0, 1'b0})
                    begin errors++; $display("FAIL rnd%0d_done: got wbv=%b sel=%b ev=%b want %b 0000 0", i, wb_valid_o, cache_sel_o, exc_valid_o, !st); end
                if (!st) begin
                    checks++; if ({wb_data_o, wb_rd_o} !== {rdata, rd})
                        begin errors++; $display("FAIL rnd%0d_wbdata: got d=%h rd=%0d want d=%h rd=%0d", i, wb_data_o, wb_rd_o, rdata, rd); end
                end
            end
        end
    endtask

    initial begin
        req_valid_i = 1'b0; req_store_i = 1'b0; req_funct3_i = 3'b0; req_addr_i = '0;
        req_wdata_i = '0; req_rd_i = '0; flush_i = 1'b0; cache_busy_i = 1'b0; cache_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        test_lw();
        test_sh_busy();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_mid();
        test_back_to_back_random(120);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the pipelined RV32IM core. It sits directly upstream of the data cache and accepts one load or store per request from the EX/MEM register. It converts the request to the cache's 4-bit access-select encoding and detects misaligned addresses. It then holds the access while the cache signals busy, times out stuck accesses, and delivers load results to the MEM/WB stage.

## Interface
Parameters:
- `BUSY_TIMEOUT`, default 15: max consecutive busy cycles before an access fault; legal range 1..255.

Ports:
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: EX/MEM holds a memory instruction.
- `req_ready_o` output 1: unit can accept a request this cycle.
- `req_store_i` input 1: 1 = store, 0 = load.
- `req_funct3_i` input 3: RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr_i` input 32: effective address.
- `req_wdata_i` input 32: store data, unshifted; byte in [7:0], half in [15:0].
- `req_rd_i` input 5: load destination register.
- `flush_i` input 1: pipeline flush.
- `cache_addr_o` output 32: address to the cache.
- `cache_wdata_o` output 32: write data to the cache.
- `cache_sel_o` output 4: access select to the cache.
- `cache_rdata_i` input 32: extended load data from the cache.
- `cache_busy_i` input 1: cache cannot complete this cycle.
- `wb_valid_o` output 1: one-cycle pulse, load result valid.
- `wb_data_o` output 32: load result.
- `wb_rd_o` output 5: load destination.
- `exc_valid_o` output 1: one-cycle pulse, exception.
- `exc_cause_o` output 4: 4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault.
- `exc_addr_o` output 32: faulting address (mtval).

## Operation
- `cache_sel_o` encoding:
  - Bit 3 = access active; `4'b0000` = idle.
  - Loads: LB 1000, LH 1001, LW 1010, LBU 1100, LHU 1101.
  - Stores: SB 1011, SH 1110, SW 1111.
- Illegal funct3 (load 011/110/111, store 011–111) is treated as LW/SW.
- Misalignment:
  - Half access: addr[0] ≠ 0.
  - Word access: addr[1:0] ≠ 0.
  - A misaligned request never reaches the cache.
- FSM states:
  - IDLE: `req_ready_o` = 1.
    - Valid request and no flush: latch addr, wdata, sel, rd and store flag.
    - Aligned request goes to ACCESS; misaligned goes to EXC.
    - `flush_i` in IDLE drops the incoming request.
  - ACCESS: `cache_sel_o`, `cache_addr_o` and `cache_wdata_o` are driven from the latched values.
    - `cache_busy_i` = 0: the access completes. A load captures `cache_rdata_i` into `wb_data_o` and sets `wb_valid_o` for the next cycle. The FSM returns to IDLE.
    - `cache_busy_i` = 1: the busy counter increments. When the counter reaches `BUSY_TIMEOUT` with busy still high, the FSM goes to EXC with cause 5 or 7.
  - EXC: `exc_valid_o` = 1 for exactly one cycle, with cause and address; the FSM then returns to IDLE.
- `flush_i` during ACCESS:
  - A store still completes; stores are not revocable.
  - A load completes on the cache side, but its `wb_valid_o` is suppressed.
  - A pending timeout exception is suppressed; the FSM returns to IDLE silently.
- Loads to rd = x0 perform the access and pulse `wb_valid_o`; the register file discards them.
- Stores never pulse `wb_valid_o`.

## Timing
- Reset values:
  - FSM = IDLE, busy counter = 0.
  - `req_ready_o` = 1, `cache_sel_o` = 0, `cache_addr_o` = 0, `cache_wdata_o` = 0.
  - `wb_valid_o` = 0, `wb_data_o` = 0, `wb_rd_o` = 0.
  - `exc_valid_o` = 0, `exc_cause_o` = 0, `exc_addr_o` = 0.
- Load, no busy: accepted at cycle 0, cache access at cycle 1, `wb_valid_o` at cycle 2. Next acceptance at cycle 2.
- Each busy cycle adds one cycle of latency.
- Misaligned request: accepted at cycle 0, `exc_valid_o` at cycle 1.
- Back-to-back throughput: one access per 2 cycles.
- `req_ready_o` is combinational from state only, never from `req_valid_i`.
- `cache_sel_o` returns to 0 in the cycle after completion or timeout.
- Busy counter: 8-bit, cleared on entry to ACCESS, saturates.
- Reset asserted mid-access: all state clears immediately and `cache_sel_o` drops to 0 asynchronously. No `wb_valid_o` or exception is produced.

## Structure
- Shared package `mem_pkg` holds:
  - The `cache_sel` localparams: SEL_IDLE, SEL_LB, SEL_LH, SEL_LW, SEL_LBU, SEL_LHU, SEL_SB, SEL_SH, SEL_SW.
  - The exception cause constants.
  - The FSM state encoding.
- The data cache imports the same select constants.
- One sub-module is natural: `lsu_decode`. It is combinational: funct3 + store flag → sel, plus the misalignment flag.

## Test plan
- LW from 0x100 holding 0xDEADBEEF, busy = 0 → `cache_sel_o` = 1010 at cycle 1; `wb_valid_o` = 1, `wb_data_o` = 0xDEADBEEF, `wb_rd_o` = 5 at cycle 2.
- SH data 0x1234ABCD to 0x202, busy high for 3 cycles → `cache_sel_o` = 1110 held 4 cycles with address 0x202; no `wb_valid_o`; `req_ready_o` low throughout.
- LH at 0x101 → no cache access (`cache_sel_o` stays 0); `exc_valid_o` pulse with cause 4, `exc_addr_o` = 0x101.
- SW to 0x300, busy stuck high with `BUSY_TIMEOUT` = 4 → exception cause 7, `exc_addr_o` = 0x300, after 4 busy cycles; then IDLE.
- LB with `flush_i` asserted in ACCESS → access completes, `wb_valid_o` stays 0; a request presented with `flush_i` high in IDLE is dropped.
- Reset pulled low during a busy LW → all outputs return to reset values immediately; no stale `wb_valid_o` after release.
